// File: rtl/combat_resolver_pkg.sv
// rtl/combat_resolver_pkg.sv - shared player/game state encodings for the combat resolver
package t03_combat_pkg;

   typedef enum logic [1:0] {
      PS_INIT     = 2'd0,
      PS_PUNCHING = 2'd1,
      PS_BLOCKING = 2'd2
   } player_state_e;

   typedef enum logic [1:0] {
      GS_IDLE  = 2'd0,
      GS_FIGHT = 2'd1,
      GS_OVER  = 2'd2
   } game_state_e;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;
   localparam logic [1:0] WIN_DRAW = 2'd3;

   // Encoding 3 is unused by the player FSM and behaves like INIT.
   function automatic player_state_e norm_state(input logic [1:0] s);
      return (s == 2'd3) ? PS_INIT : player_state_e'(s);
   endfunction

endpackage

// File: rtl/combat_resolver_if.sv
// rtl/combat_resolver_if.sv - player inputs and round/health outputs of the combat resolver
interface combat_resolver_if #(
   parameter int HEALTH_W = 3
);
   logic                finished;
   logic                start;
   logic [1:0]          p1_state;
   logic [1:0]          p2_state;
   logic                p1_resting;
   logic                p2_resting;
   logic [HEALTH_W-1:0] p1_health;
   logic [HEALTH_W-1:0] p2_health;
   logic [1:0]          game_state;
   logic [1:0]          winner;
   logic                p1_hit;
   logic                p2_hit;

   modport master (
      output finished, start, p1_state, p2_state, p1_resting, p2_resting,
      input  p1_health, p2_health, game_state, winner, p1_hit, p2_hit
   );

   modport slave (
      input  finished, start, p1_state, p2_state, p1_resting, p2_resting,
      output p1_health, p2_health, game_state, winner, p1_hit, p2_hit
   );
endinterface

// File: rtl/combat_resolver_stun_timer.sv
// rtl/combat_resolver_stun_timer.sv - per-player post-hit invulnerability counter
module combat_stun_timer #(
   parameter int                STUN_W      = 4,
   parameter logic [STUN_W-1:0] STUN_FRAMES = 4'd2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic tick_i,
   input  logic load_i,
   output logic active_o
);
   localparam logic [STUN_W-1:0] ONE = STUN_W'(1);

   logic [STUN_W-1:0] count_q, count_d;

   // A fresh hit reloads the full window even if a tick arrives on the same edge.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = STUN_FRAMES;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign active_o = (count_q != '0);

endmodule

// File: rtl/combat_resolver.sv
// rtl/combat_resolver.sv - punch landing, health bookkeeping and round state machine
module combat_resolver
   import t03_combat_pkg::*;
#(
   parameter int                  HEALTH_W     = 3,
   parameter logic [HEALTH_W-1:0] MAX_HEALTH   = 3'd3,
   parameter logic [HEALTH_W-1:0] PUNCH_DAMAGE = 3'd1,
   parameter int                  STUN_W       = 4,
   parameter logic [STUN_W-1:0]   STUN_FRAMES  = 4'd2
) (
   input logic               clk,
   input logic               rst,
   combat_resolver_if.slave  bus
);

   function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                   input logic [HEALTH_W-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   game_state_e         state_q, state_d;
   logic [1:0]          winner_q, winner_d;
   logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
   logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
   player_state_e       prev1_q, prev1_d;
   player_state_e       prev2_q, prev2_d;
   logic                p1_hit_q, p1_hit_d;
   logic                p2_hit_q, p2_hit_d;

   player_state_e cur1, cur2;
   logic          onset1, onset2;
   logic          prot1, prot2;
   logic          stun1_active, stun2_active;
   logic          land_p1, land_p2;
   logic          restart;
   logic          frame_tick;

   assign cur1   = norm_state(bus.p1_state);
   assign cur2   = norm_state(bus.p2_state);
   assign onset1 = (cur1 == PS_PUNCHING) && (prev1_q != PS_PUNCHING);
   assign onset2 = (cur2 == PS_PUNCHING) && (prev2_q != PS_PUNCHING);
   assign prot1  = ((cur1 == PS_BLOCKING) && !bus.p1_resting) || stun1_active;
   assign prot2  = ((cur2 == PS_BLOCKING) && !bus.p2_resting) || stun2_active;

   // Stun only counts down on frames of a live round, so OVER freezes it.
   assign frame_tick = (state_q == GS_FIGHT) && bus.finished;

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      p1_health_d = p1_health_q;
      p2_health_d = p2_health_q;
      prev1_d     = prev1_q;
      prev2_d     = prev2_q;
      p1_hit_d    = 1'b0;
      p2_hit_d    = 1'b0;
      land_p1     = 1'b0;
      land_p2     = 1'b0;
      restart     = 1'b0;

      case (state_q)
         GS_IDLE, GS_OVER: begin
            if (bus.start) begin
               restart     = 1'b1;
               state_d     = GS_FIGHT;
               winner_d    = WIN_NONE;
               p1_health_d = MAX_HEALTH;
               p2_health_d = MAX_HEALTH;
               prev1_d     = cur1;
               prev2_d     = cur2;
            end
         end
         GS_FIGHT: begin
            if (bus.finished) begin
               prev1_d  = cur1;
               prev2_d  = cur2;
               land_p1  = onset2 && !prot1;
               land_p2  = onset1 && !prot2;
               p1_hit_d = land_p1;
               p2_hit_d = land_p2;
               if (land_p1) p1_health_d = sat_sub(p1_health_q, PUNCH_DAMAGE);
               if (land_p2) p2_health_d = sat_sub(p2_health_q, PUNCH_DAMAGE);
               if ((p1_health_d == '0) || (p2_health_d == '0)) begin
                  state_d = GS_OVER;
                  if ((p1_health_d == '0) && (p2_health_d == '0)) winner_d = WIN_DRAW;
                  else if (p1_health_d == '0)                      winner_d = WIN_P2;
                  else                                              winner_d = WIN_P1;
               end
            end
         end
         default: state_d = GS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= GS_IDLE;
         winner_q    <= WIN_NONE;
         p1_health_q <= MAX_HEALTH;
         p2_health_q <= MAX_HEALTH;
         prev1_q     <= PS_INIT;
         prev2_q     <= PS_INIT;
         p1_hit_q    <= 1'b0;
         p2_hit_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         p1_health_q <= p1_health_d;
         p2_health_q <= p2_health_d;
         prev1_q     <= prev1_d;
         prev2_q     <= prev2_d;
         p1_hit_q    <= p1_hit_d;
         p2_hit_q    <= p2_hit_d;
      end
   end

   combat_stun_timer #(.STUN_W(STUN_W), .STUN_FRAMES(STUN_FRAMES)) u_stun_p1 (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (restart),
      .tick_i   (frame_tick),
      .load_i   (land_p1),
      .active_o (stun1_active)
   );

   combat_stun_timer #(.STUN_W(STUN_W), .STUN_FRAMES(STUN_FRAMES)) u_stun_p2 (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (restart),
      .tick_i   (frame_tick),
      .load_i   (land_p2),
      .active_o (stun2_active)
   );

   assign bus.p1_health  = p1_health_q;
   assign bus.p2_health  = p2_health_q;
   assign bus.game_state = state_q;
   assign bus.winner     = winner_q;
   assign bus.p1_hit     = p1_hit_q;
   assign bus.p2_hit     = p2_hit_q;

endmodule

// File: tb/tb_combat_resolver.sv
// tb/tb_combat_resolver.sv - directed vector table plus randomized run against a reference model
module tb_combat_resolver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   combat_resolver_if #(.HEALTH_W(3)) ifc ();

   combat_resolver dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         fin;
      bit         st;
      logic [1:0] s1;
      logic [1:0] s2;
      bit         r1;
      bit         r2;
      int         h1, h2, gs, win, hit1, hit2;
   } vec_t;

   vec_t vecs[$];

   // Reference model: plain integer view of the round rules
   int m_gs, m_win, m_h1, m_h2, m_stun1, m_stun2, m_prev1, m_prev2, m_hit1, m_hit2;

   function automatic vec_t v(bit fin, bit st, logic [1:0] s1, logic [1:0] s2, bit r1, bit r2,
                              int h1, int h2, int gs, int win, int hit1, int hit2);
      vec_t x;
      x.fin = fin; x.st = st; x.s1 = s1; x.s2 = s2; x.r1 = r1; x.r2 = r2;
      x.h1 = h1; x.h2 = h2; x.gs = gs; x.win = win; x.hit1 = hit1; x.hit2 = hit2;
      return x;
   endfunction

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_all(string tag, int h1, int h2, int gs, int win, int hit1, int hit2);
      chk({tag, " p1_health"},  int'(ifc.p1_health),  h1);
      chk({tag, " p2_health"},  int'(ifc.p2_health),  h2);
      chk({tag, " game_state"}, int'(ifc.game_state), gs);
      chk({tag, " winner"},     int'(ifc.winner),     win);
      chk({tag, " p1_hit"},     int'(ifc.p1_hit),     hit1);
      chk({tag, " p2_hit"},     int'(ifc.p2_hit),     hit2);
   endtask

   task automatic step(bit r, bit fin, bit st, logic [1:0] s1, logic [1:0] s2, bit r1, bit r2);
      rst            = r;
      ifc.finished   = fin;
      ifc.start      = st;
      ifc.p1_state   = s1;
      ifc.p2_state   = s2;
      ifc.p1_resting = r1;
      ifc.p2_resting = r2;
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(bit r, bit fin, bit st, int s1, int s2, bit r1, bit r2);
      int  n1, n2;
      bit  on1, on2, pr1, pr2, l1, l2;
      n1 = (s1 == 3) ? 0 : s1;
      n2 = (s2 == 3) ? 0 : s2;
      m_hit1 = 0;
      m_hit2 = 0;
      if (r) begin
         m_gs = 0; m_win = 0; m_h1 = 3; m_h2 = 3;
         m_stun1 = 0; m_stun2 = 0; m_prev1 = 0; m_prev2 = 0;
      end else if (m_gs != 1) begin
         if (st) begin
            m_gs = 1; m_win = 0; m_h1 = 3; m_h2 = 3;
            m_stun1 = 0; m_stun2 = 0; m_prev1 = n1; m_prev2 = n2;
         end
      end else if (fin) begin
         on1 = (n1 == 1) && (m_prev1 != 1);
         on2 = (n2 == 1) && (m_prev2 != 1);
         pr1 = ((n1 == 2) && !r1) || (m_stun1 > 0);
         pr2 = ((n2 == 2) && !r2) || (m_stun2 > 0);
         l1  = on2 && !pr1;
         l2  = on1 && !pr2;
         m_prev1 = n1;
         m_prev2 = n2;
         if (l1) begin
            m_h1 = (m_h1 > 1) ? m_h1 - 1 : 0; m_stun1 = 2; m_hit1 = 1;
         end else if (m_stun1 > 0) m_stun1--;
         if (l2) begin
            m_h2 = (m_h2 > 1) ? m_h2 - 1 : 0; m_stun2 = 2; m_hit2 = 1;
         end else if (m_stun2 > 0) m_stun2--;
         if (m_h1 == 0 || m_h2 == 0) begin
            m_gs  = 2;
            m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : ((m_h1 == 0) ? 2 : 1);
         end
      end
   endtask

   localparam logic [1:0] I = 2'd0, P = 2'd1, B = 2'd2, X = 2'd3;

   initial begin
      // fin st  s1 s2 r1 r2 -> h1 h2 gs win hit1 hit2
      vecs.push_back(v(0, 1, I, I, 0, 0, 3, 3, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, I, 0, 0, 3, 2, 1, 0, 0, 1));
      vecs.push_back(v(0, 0, P, I, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, B, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, B, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, B, 0, 1, 3, 1, 1, 0, 0, 1));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, I, 0, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, P, 0, 0, 2, 1, 1, 0, 1, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 2, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 2, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, P, 0, 0, 1, 1, 1, 0, 1, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 1, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 1, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, P, 0, 0, 0, 0, 2, 3, 1, 1));
      vecs.push_back(v(1, 0, I, I, 0, 0, 0, 0, 2, 3, 0, 0));
      vecs.push_back(v(1, 0, P, P, 0, 0, 0, 0, 2, 3, 0, 0));
      vecs.push_back(v(0, 1, P, I, 0, 0, 3, 3, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, I, 0, 0, 3, 3, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 3, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, I, 0, 0, 3, 2, 1, 0, 0, 1));
      vecs.push_back(v(1, 0, X, I, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 2, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, I, 0, 0, 3, 1, 1, 0, 0, 1));
      vecs.push_back(v(0, 1, I, I, 0, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, I, 0, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, P, I, 0, 0, 3, 0, 2, 1, 0, 1));
      vecs.push_back(v(0, 1, I, I, 0, 0, 3, 3, 1, 0, 0, 0));
      vecs.push_back(v(1, 0, I, P, 0, 0, 2, 3, 1, 0, 1, 0));

      step(1, 0, 0, I, I, 0, 0);
      step(1, 0, 0, I, I, 0, 0);
      chk_all("reset", 3, 3, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(0, vecs[i].fin, vecs[i].st, vecs[i].s1, vecs[i].s2, vecs[i].r1, vecs[i].r2);
         chk_all($sformatf("vec%0d", i), vecs[i].h1, vecs[i].h2, vecs[i].gs,
                 vecs[i].win, vecs[i].hit1, vecs[i].hit2);
      end

      // Reset in mid-round wins over start and finished
      step(1, 1, 1, P, P, 0, 0);
      chk_all("mid_rst", 3, 3, 0, 0, 0, 0);

      model_step(1, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         bit         r, fin, st, r1, r2;
         logic [1:0] s1, s2;
         r   = ($urandom_range(0, 299) == 0);
         fin = $urandom_range(0, 1) == 1;
         st  = ($urandom_range(0, 24) == 0);
         s1  = 2'($urandom_range(0, 3));
         s2  = 2'($urandom_range(0, 3));
         r1  = $urandom_range(0, 1) == 1;
         r2  = $urandom_range(0, 1) == 1;
         model_step(r, fin, st, int'(s1), int'(s2), r1, r2);
         step(r, fin, st, s1, s2, r1, r2);
         chk_all("rand", m_h1, m_h2, m_gs, m_win, m_hit1, m_hit2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Downstream consumer of both players' state FSM outputs (2-bit player_state and resting per player).
- Detects punch onsets and decides whether each punch lands against the opponent's block or stun invulnerability.
- Maintains both health counters and runs the round state machine (IDLE / FIGHT / OVER), reporting the winner to the display and sound logic.
- Evaluates only on the game frame strobe `finished`, the same strobe that advances the player FSMs.

Parameters:
- HEALTH_W, 3, width of each health counter.
- MAX_HEALTH, 3'd3, health loaded at reset and at round start.
- PUNCH_DAMAGE, 3'd1, health removed per landed punch.
- STUN_W, 4, width of the stun counter.
- STUN_FRAMES, 4'd2, number of frames a player is invulnerable after being hit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- finished  in  1  frame strobe; all combat evaluation is gated by it
- start  in  1  round start request; sampled every cycle
- p1_state  in  2  player 1 state (INIT=0, PUNCHING=1, BLOCKING=2)
- p2_state  in  2  player 2 state
- p1_resting  in  1  player 1 resting flag
- p2_resting  in  1  player 2 resting flag
- p1_health  out  HEALTH_W  player 1 health
- p2_health  out  HEALTH_W  player 2 health
- game_state  out  2  IDLE=0, FIGHT=1, OVER=2
- winner  out  2  0=none, 1=P1, 2=P2, 3=draw
- p1_hit  out  1  one-cycle pulse: player 1 took damage
- p2_hit  out  1  one-cycle pulse: player 2 took damage

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - health = MAX_HEALTH for both players
  - game_state = IDLE, winner = 0
  - p1_hit = p2_hit = 0
  - both stun counters = 0
  - both prev_state registers = INIT
- IDLE:
  - Health is held at MAX_HEALTH.
  - start=1 on any cycle → FIGHT on the next edge.
  - On the same edge, prev_state registers load the current p*_state, so a punch held across start does not count.
- FIGHT:
  - Nothing changes on cycles with finished=0, except that hit pulses clear.
  - start is ignored.
  - On a finished=1 edge:
    - Onset: onset_px = (px_state==PUNCHING) && (prev_px != PUNCHING).
    - prev_px <= px_state.
    - Protection: protected_py = (py_state==BLOCKING && !py_resting) || (stun_py != 0).
    - Landing: a hit lands on py iff onset_px && !protected_py.
    - On a landed hit: py_health <= sat_sub(py_health, PUNCH_DAMAGE), clamped at 0; stun_py <= STUN_FRAMES; py_hit = 1 for exactly this one cycle.
    - Otherwise stun_py decrements while nonzero, saturating at 0.
    - Simultaneous onsets: both sides are evaluated independently from pre-edge values, so both can land on the same frame.
    - Hit pulses deassert on the next clk edge regardless of finished.
- Round end:
  - When the post-update health of either player is 0, game_state goes to OVER on the same edge as the damage.
  - winner = 2 if P1 reaches 0 alone, 1 if P2 reaches 0 alone, 3 if both reach 0 on the same frame.
- OVER:
  - Health, winner and stun counters are frozen, and further onsets are ignored.
  - start=1 → FIGHT, with health = MAX_HEALTH, winner = 0, stun = 0, and prev_state loaded as in IDLE.
- rst mid-round returns to the reset values on the next edge; rst overrides start and finished.
- Arithmetic: all health math is unsigned HEALTH_W bits and never wraps below 0. An invalid p*_state (3) is treated as INIT.

Decomposition:
- Package t03_combat_pkg holds:
  - player_state enum, shared with the player FSM
  - game_state enum
  - winner encoding constants
- Sub-module combat_stun_timer, instantiated once per player:
  - inputs: clk, rst, clear, tick (finished), load
  - outputs: active (count != 0)
  - load takes priority over tick-decrement.

Test Plan:
- Reset and start: rst → health 3/3, IDLE, winner 0; start pulse → game_state=1 next cycle.
- Clean hit: p1_state INIT→PUNCHING on a finished frame, p2 INIT → p2_health 3→2, p2_hit high exactly one clk, p1_health stays 3.
- Block: p2_state=BLOCKING with p2_resting=0 while P1 punch onset → no damage, no pulse. Repeat with p2_resting=1 → p2_health decrements.
- Stun: P1 lands a hit, then a second onset on the next finished frame (stun 2→1) → no damage. A third onset after 2 more frames → damage.
- Simultaneous KO: both health 1, both punch onsets on the same frame → both 0, game_state=OVER, winner=3. Later onsets are ignored.
- Held punch and restart: in OVER, hold p1_state=PUNCHING and pulse start → health 3/3, winner 0, FIGHT, and no hit from the held punch until P1 leaves and re-enters PUNCHING.
